lc3_memaccess: RTL
==================

Name: lc3_memaccess

Overview:
- LC3 memory-access stage, directly downstream of the execute stage.
- Consumes the execute-stage outputs (IR_Exec, pcout as effective address, M_Data as store data, Mem_Control_out as indirect flag).
- Sequences LD/LDR/LDI/ST/STR/STI through a req/ack data-memory port and returns load data (memout) to writeback.
- Handles LDI/STI as a two-access indirect sequence and flags memory non-response with a timeout.

Parameters:
- ACK_TIMEOUT, 15: cycles mem_req may stay high without mem_ack before abort; legal range 1..255.
- AW, 16: data-memory address width; must equal 16 for LC3.

Ports:
- clock  input  1  single stage clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable_mem  input  1  start strobe; sampled only in IDLE.
- IR_Exec  input  16  instruction from execute; opcode = [15:12].
- pcout  input  16  effective address from execute.
- M_Data  input  16  store data from execute.
- Mem_Control_out  input  1  1 = indirect access (LDI/STI).
- mem_req  output  1  memory request; held until ack or timeout.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  16  memory address; stable while mem_req.
- mem_din  output  16  write data; stable while mem_req.
- mem_ack  input  1  memory acknowledge; completes the access on the edge where mem_req & mem_ack.
- mem_dout  input  16  read data; valid when mem_ack.
- memout  output  16  load result to writeback; holds until the next load completes.
- mem_done  output  1  one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- mem_err  output  1  timeout flag; sticky until the next accepted start.

Behaviour:
- Reset: reset low forces IDLE asynchronously, including mid-access.
  - mem_req, mem_we, mem_done, busy and mem_err = 0.
  - mem_addr, mem_din and memout = 16'h0000.
  - Timeout counter = 0.
- Start capture (IDLE & enable_mem): latch opcode, pcout, M_Data and Mem_Control_out. Inputs are not re-sampled until the next IDLE. enable_mem while busy is ignored.
- Decode:
  - Loads: 0010 LD, 0110 LDR, 1010 LDI.
  - Stores: 0011 ST, 0111 STR, 1011 STI.
  - Indirect = Mem_Control_out, honoured only for opcode[15:13] = 101.
  - Any other opcode goes to DONE with no memory access; memout is unchanged.
- States:
  - IDLE -> IND_RD if indirect; -> ACCESS if LD/LDR/ST/STR; -> DONE otherwise.
  - IND_RD: mem_req=1, mem_we=0, mem_addr=latched pcout. On ack: latch mem_dout as the final address, go to ACCESS.
  - ACCESS: mem_req=1, mem_addr = final address (latched pcout if direct).
    - Stores: mem_we=1, mem_din = latched M_Data.
    - Loads: mem_we=0. On ack, memout <= mem_dout.
    - On ack, go to DONE.
  - DONE: mem_done=1 for exactly one cycle, mem_req=0, then IDLE.
- Handshake:
  - mem_req deasserts in the cycle after the acking edge; back-to-back IND_RD -> ACCESS re-asserts mem_req immediately with the new address.
  - mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory (ack in the same cycle as req), start edge = T0:
  - Direct: req in T1, mem_done in T2.
  - Indirect: req in T1 and T2, mem_done in T3.
  - Non-memory opcode: mem_done in T1.
- Timeout:
  - The counter clears on entry to IND_RD/ACCESS and increments each cycle mem_req=1 without ack.
  - Abort happens on the edge where the counter reaches ACK_TIMEOUT: go to DONE, set mem_err=1 and drop mem_req.
  - On abort, memout = 16'h0000 for loads; no write is considered performed for stores.
  - A timeout in IND_RD skips ACCESS.
- Simultaneous events: an ack on the same edge the counter reaches ACK_TIMEOUT counts as success (no error).
- busy is 1 from the cycle after start through DONE inclusive.
- No arithmetic is performed; all addresses pass through unmodified at 16 bits, with no wrap logic needed.

Test Plan:
- LD: IR_Exec=16'h2005, pcout=16'h3006, ack same cycle with mem_dout=16'hBEEF -> T1 mem_req=1, mem_we=0, mem_addr=16'h3006; T2 mem_done=1, memout=16'hBEEF, mem_err=0.
- STR with 2 wait states: IR_Exec=16'h7042, pcout=16'h4010, M_Data=16'h1234, ack in the third req cycle -> mem_req high 3 cycles, mem_we=1, mem_addr=16'h4010, mem_din=16'h1234 stable throughout; mem_done one cycle later; memout unchanged.
- LDI: IR_Exec=16'hA201, pcout=16'h3000, Mem_Control_out=1; mem[16'h3000]=16'h5000, mem[16'h5000]=16'h00AA -> T1 read at 16'h3000, T2 read at 16'h5000, T3 mem_done with memout=16'h00AA.
- Timeout: ACK_TIMEOUT=15, ST with mem_ack tied low -> mem_req high exactly 15 cycles, then mem_done=1 and mem_err=1; mem_err clears on the next accepted enable_mem.
- Non-memory opcode and busy guard: ADD IR_Exec=16'h1021 -> mem_done at T1, no mem_req, memout unchanged. A second enable_mem pulsed during an in-flight LD is ignored (exactly one mem_done).
- Async reset: assert reset low mid-ACCESS of an STI -> mem_req, busy and mem_done drop to 0 immediately without a clock edge; all outputs at reset values; the next LD after release completes normally.

Source files
------------

// File: rtl/lc3_memaccess.sv
// ---------------------------------------------------------------------------
// lc3_memaccess
//
// LC3 memory-access stage. Takes the instruction, effective address and
// store data from execute, runs the LD/LDR/LDI/ST/STR/STI data-memory
// transaction over a req/ack port, and hands load data to writeback.
// LDI/STI take two accesses: the first reads the pointer and the second
// uses that pointer as the address. An access with no ack within
// ACK_TIMEOUT request cycles is aborted and flagged on mem_err.
//
// Ports
//   clock            stage clock, all state on the rising edge
//   reset            asynchronous, active-low
//   enable_mem       start strobe, only looked at while idle
//   IR_Exec          instruction from execute (opcode in [15:12])
//   pcout            effective address from execute
//   M_Data           store data from execute
//   Mem_Control_out  1 = indirect access (LDI/STI only)
//   mem_req/mem_we/mem_addr/mem_din   request side of the data-memory port
//   mem_ack/mem_dout                  response side of the data-memory port
//   memout           last completed load value, held between loads
//   mem_done         one-cycle completion pulse
//   busy             high in every state except idle
//   mem_err          timeout flag, sticky until the next accepted start
// ---------------------------------------------------------------------------
module lc3_memaccess #(
  parameter int ACK_TIMEOUT = 15,  // legal range 1..255
  parameter int AW          = 16   // must be 16 for LC3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_mem,
  input  logic [15:0]   IR_Exec,
  input  logic [AW-1:0] pcout,
  input  logic [15:0]   M_Data,
  input  logic          Mem_Control_out,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic          mem_ack,
  input  logic [15:0]   mem_dout,
  output logic [15:0]   memout,
  output logic          mem_done,
  output logic          busy,
  output logic          mem_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IND_RD,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0110) || (op == 4'b1010);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == 4'b0011) || (op == 4'b0111) || (op == 4'b1011);
  endfunction

  state_t     state;
  logic [3:0] op_q;      // opcode captured at start
  logic [7:0] ack_cnt;   // request cycles seen without ack in this access

  // Start decode, only meaningful in IDLE.
  logic [3:0] start_op;
  logic       start_ind;
  logic       start_direct;
  logic       timeout_hit;

  // Operand bits of the instruction do not affect this stage.
  logic       unused_ir;
  assign unused_ir = ^IR_Exec[11:0];

  assign start_op     = IR_Exec[15:12];
  // Indirection is honoured only for the LDI/STI opcode pair (101x).
  assign start_ind    = Mem_Control_out && (start_op[3:1] == 3'b101);
  assign start_direct = (start_op == 4'b0010) || (start_op == 4'b0110) ||
                        (start_op == 4'b0011) || (start_op == 4'b0111);

  // The counter "reaches" ACK_TIMEOUT on the edge it would step to it;
  // an ack on that same edge wins, so mem_ack is excluded here.
  assign timeout_hit  = mem_req && !mem_ack && ((ack_cnt + 8'd1) == TIMEOUT);

  // NOTE: all state below is assigned with <= so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= 4'h0;
      ack_cnt  <= 8'd0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 16'h0000;
      memout   <= 16'h0000;
      mem_done <= 1'b0;
      busy     <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      mem_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable_mem) begin
            op_q    <= start_op;
            mem_din <= M_Data;
            mem_err <= 1'b0;
            busy    <= 1'b1;
            ack_cnt <= 8'd0;
            if (start_ind) begin
              state    <= S_IND_RD;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pcout;
            end else if (start_direct) begin
              state    <= S_ACCESS;
              mem_req  <= 1'b1;
              mem_we   <= op_is_store(start_op);
              mem_addr <= pcout;
            end else begin
              // Not a memory instruction: finish without touching the port.
              state    <= S_DONE;
              mem_done <= 1'b1;
            end
          end
        end

        S_IND_RD, S_ACCESS: begin
          if (mem_req && mem_ack) begin
            if (state == S_IND_RD) begin
              // Pointer read done; keep mem_req high and switch straight to
              // the final address so the second access starts next cycle.
              mem_addr <= mem_dout;
              mem_we   <= op_is_store(op_q);
              ack_cnt  <= 8'd0;
              state    <= S_ACCESS;
            end else begin
              if (op_is_load(op_q)) begin
                memout <= mem_dout;
              end
              mem_req  <= 1'b0;
              mem_we   <= 1'b0;
              mem_done <= 1'b1;
              state    <= S_DONE;
            end
          end else if (timeout_hit) begin
            // Abort: a load returns zero, a store counts as not written.
            if (op_is_load(op_q)) begin
              memout <= 16'h0000;
            end
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_err  <= 1'b1;
            mem_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
